// File: rtl/data_memory_bx.sv
// Byte-addressable data memory for the load/store stage: byte/half/word access,
// one-cycle registered response, error flagging and optional post-reset clear.
module data_memory_bx #(
  parameter int unsigned DEPTH          = 128,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              clear_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] Limit = (ADDR_W+1)'(4 * DEPTH);

  typedef enum logic {StClear, StIdle} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               clr_we;
  logic [31:0]        mem [DEPTH];

  logic               accept, req_err, wr_en;
  logic [1:0]         lane;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         be;
  logic [31:0]        wdata_lanes;
  logic [31:0]        rword, load_data;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  logic               rsp_valid_q, rsp_err_q;
  logic [31:0]        rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = StIdle;
      end
      StIdle: ;
      default: state_d = StIdle;
    endcase
  end

  assign req_ready  = (state_q == StIdle) & ~reset;
  assign clear_done = (state_q == StIdle) & ~reset;
  assign accept     = req_valid & req_ready;

  assign lane = req_addr[1:0];
  assign idx  = req_addr[IDX_W+1:2];

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({1'b0, req_addr} >= Limit) req_err = 1'b1;
  end

  assign wr_en = accept & req_we & ~req_err;

  // Replicate store data across lanes so the byte enables alone pick placement.
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = req_wdata;
    unique case (req_size)
      2'b00: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  assign rword    = mem[idx];
  assign byte_sel = rword[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = '0;
    unique case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
      2'b10:   load_data = rword;
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept & req_err;
      rsp_rdata_q <= (accept & ~req_we & ~req_err) ? load_data : '0;
    end
  end

  // Gate with reset so outputs are zero from the very cycle reset rises.
  assign rsp_valid = rsp_valid_q & ~reset;
  assign rsp_err   = rsp_err_q & ~reset;
  assign rsp_rdata = reset ? '0 : rsp_rdata_q;

endmodule
